// File: rtl/dsp_pkg.sv
// dsp_pkg: shared mode encodings, FSM state type and step-count helper for dsp_tiled_mac.
package dsp_pkg;
    localparam logic [1:0] MODE_LL = 2'd0;
    localparam logic [1:0] MODE_LF = 2'd1;
    localparam logic [1:0] MODE_FF = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int unsigned step_count(input logic [1:0] mode, input int unsigned nt);
        return mode == MODE_LL ? 1 : mode == MODE_LF ? nt : nt * nt;
    endfunction
endpackage

// File: rtl/tile_mult.sv
// tile_mult: combinational TILE x TILE unsigned multiplier; hook for the Wallace/Dadda PPM reduction.
module tile_mult #(
    parameter int TILE = 16
) (
    input  logic [TILE-1:0]   a,
    input  logic [TILE-1:0]   b,
    output logic [2*TILE-1:0] p
);
    assign p = (2*TILE)'(a) * (2*TILE)'(b);
endmodule

// File: rtl/dsp_tiled_mac.sv
// dsp_tiled_mac: multi-precision unsigned MAC issuing one TILE x TILE partial product per cycle
// into a wide accumulator that can be shifted and fed back as the next initial sum.
module dsp_tiled_mac
    import dsp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int TILE       = 16,
    parameter int ACC_W      = 2*WIDTH+8,
    parameter int SHIFT_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      aa,
    input  logic [WIDTH-1:0]      bb,
    input  logic [2*WIDTH-1:0]    cc,
    input  logic                  mac,
    input  logic [SHIFT_BITS-1:0] shift_amount,
    input  logic                  shift_dir,
    output logic                  busy,
    output logic [ACC_W-1:0]      out,
    output logic                  out_valid
);
    localparam int NT = WIDTH / TILE;
    localparam int IW = NT > 1 ? $clog2(NT) : 1;
    localparam int CW = $clog2(NT*NT+1);

    state_t            state;
    logic [1:0]        mode_r;
    logic [WIDTH-1:0]  aa_r, bb_r;
    logic [IW-1:0]     i, j;
    logic [CW-1:0]     cnt;
    logic [ACC_W-1:0]  acc, fb, pp_ext;
    logic [2*TILE-1:0] pp;
    logic              last;

    assign out = acc;

    tile_mult #(.TILE(TILE)) u_mult (
        .a(aa_r[int'(i)*TILE +: TILE]),
        .b(bb_r[int'(j)*TILE +: TILE]),
        .p(pp)
    );

    always_comb begin
        fb     = shift_dir ? acc >> shift_amount : acc << shift_amount;
        pp_ext = ACC_W'(pp) << ((int'(i) + int'(j)) * TILE);
        last   = cnt == CW'(step_count(mode_r, NT) - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_r    <= '0;
            aa_r      <= '0;
            bb_r      <= '0;
            i         <= '0;
            j         <= '0;
            cnt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (start) begin
                        aa_r   <= aa;
                        bb_r   <= bb;
                        mode_r <= mode;
                        acc    <= mac ? fb : ACC_W'(cc);
                        i      <= '0;
                        j      <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + pp_ext;
                    cnt <= cnt + CW'(1);
                    // j inner, i outer; mode 1 finishes before i ever advances
                    j   <= j == IW'(NT-1) ? '0 : j + IW'(1);
                    i   <= j == IW'(NT-1) ? i + IW'(1) : i;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_tiled_mac.sv
// tb_dsp_tiled_mac: directed self-checking bench for dsp_tiled_mac with hand-computed expectations.
module tb_dsp_tiled_mac;
    localparam int WIDTH = 32;
    localparam int ACC_W = 2*WIDTH+8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] aa, bb;
    logic [2*WIDTH-1:0] cc;
    logic             mac;
    logic [1:0]       shift_amount;
    logic             shift_dir;
    logic             busy;
    logic [ACC_W-1:0] out;
    logic             out_valid;

    int total = 0;
    int bad   = 0;

    int               r_lat, r_busy, r_nv;
    logic [ACC_W-1:0] r_res;

    dsp_tiled_mac #(.WIDTH(WIDTH), .TILE(16), .ACC_W(ACC_W), .SHIFT_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .aa(aa), .bb(bb), .cc(cc),
        .mac(mac), .shift_amount(shift_amount), .shift_dir(shift_dir),
        .busy(busy), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Drives one op and observes it; k counts negedges after the accepting edge.
    task automatic run_op(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] c, input logic mc, input logic [1:0] sa, input logic sd);
        @(negedge clk);
        mode = m; aa = a; bb = b; cc = c; mac = mc; shift_amount = sa; shift_dir = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_lat = -1; r_busy = 0; r_nv = 0; r_res = 'x;
        for (int k = 0; k < 40; k++) begin
            if (busy) r_busy++;
            if (out_valid) begin
                r_nv++;
                if (r_lat < 0) begin
                    r_lat = k;
                    r_res = out;
                end
            end
            if (r_lat >= 0 && !busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 0; aa = 0; bb = 0; cc = 0; mac = 0; shift_amount = 0; shift_dir = 0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%0h want=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_mode0;
        run_op(2'd0, 32'h7, 32'h3, 64'h10, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h25) begin bad++; $display("FAIL m0_out got=%0h want=25", r_res); end
        total++; if (r_lat !== 1) begin bad++; $display("FAIL m0_latency got=%0d want=1", r_lat); end
        total++; if (r_nv !== 1) begin bad++; $display("FAIL m0_valid_count got=%0d want=1", r_nv); end
        total++; if (r_busy !== 2) begin bad++; $display("FAIL m0_busy_cycles got=%0d want=2", r_busy); end
    endtask

    task automatic test_mode2_full;
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL m2_out got=%0h want=fffffffe00000001", r_res); end
        total++; if (r_lat !== 4) begin bad++; $display("FAIL m2_latency got=%0d want=4", r_lat); end
        total++; if (r_busy !== 5) begin bad++; $display("FAIL m2_busy_cycles got=%0d want=5", r_busy); end
        total++; if (r_nv !== 1) begin bad++; $display("FAIL m2_valid_count got=%0d want=1", r_nv); end
        run_op(2'd3, 32'h0001_0002, 32'h0003_0004, 64'h5, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h3_000A_0008 + 72'h5) begin bad++; $display("FAIL m3_out got=%0h want=3000a000d", r_res); end
        // full product plus full-width addend wraps past 2*WIDTH into the guard bits
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h1_FFFF_FFFE_0000_0000) begin bad++; $display("FAIL m2_carry got=%0h want=1fffffffe00000000", r_res); end
    endtask

    task automatic test_mode1;
        run_op(2'd1, 32'h2, 32'h0001_0003, 64'h0, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h2_0006) begin bad++; $display("FAIL m1_out got=%0h want=20006", r_res); end
        total++; if (r_lat !== 2) begin bad++; $display("FAIL m1_latency got=%0d want=2", r_lat); end
        run_op(2'd1, 32'hFFFF_0002, 32'h0001_0003, 64'h0, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h2_0006) begin bad++; $display("FAIL m1_ignores_aa_hi got=%0h want=20006", r_res); end
    endtask

    task automatic test_chain;
        run_op(2'd0, 32'h3, 32'h2, 64'h0, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h6) begin bad++; $display("FAIL chain_base got=%0h want=6", r_res); end
        run_op(2'd0, 32'h1, 32'h1, 64'hFF, 1'b1, 2'd1, 1'b0);
        total++; if (r_res !== 72'hD) begin bad++; $display("FAIL chain_left got=%0h want=d", r_res); end
        run_op(2'd0, 32'h1, 32'h1, 64'hFF, 1'b1, 2'd1, 1'b1);
        total++; if (r_res !== 72'h7) begin bad++; $display("FAIL chain_right got=%0h want=7", r_res); end
        run_op(2'd0, 32'h0, 32'h0, 64'h0, 1'b1, 2'd3, 1'b0);
        total++; if (r_res !== 72'h38) begin bad++; $display("FAIL chain_left3 got=%0h want=38", r_res); end
    endtask

    task automatic test_ignore_start;
        int nv = 0;
        @(negedge clk);
        mode = 2'd2; aa = 32'hFFFF_FFFF; bb = 32'hFFFF_FFFF; cc = 0; mac = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (out_valid) nv++;
            if (k == 4) begin
                total++; if (out_valid !== 1'b1 || out !== 72'hFFFF_FFFE_0000_0001) begin
                    bad++; $display("FAIL ign_result valid=%0b out=%0h want valid=1 out=fffffffe00000001", out_valid, out);
                end
            end
            if (k == 6) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_accept busy=%0b want=0", busy); end
                total++; if (out !== 72'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL ign_hold got=%0h want=fffffffe00000001", out); end
            end
            start = (k == 1 || k == 4);
            if (start) begin
                mode = 2'd0; aa = 32'h5; bb = 32'h5; cc = 64'h1;
            end
            @(negedge clk);
        end
        total++; if (nv !== 1) begin bad++; $display("FAIL ign_valid_count got=%0d want=1", nv); end
    endtask

    task automatic test_reset_abort;
        int nv = 0;
        @(negedge clk);
        mode = 2'd2; aa = 32'hFFFF_FFFF; bb = 32'hFFFF_FFFF; cc = 64'h3; mac = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (out !== '0) begin bad++; $display("FAIL abort_out got=%0h want=0", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        total++; if (nv !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", nv); end
        run_op(2'd0, 32'h2, 32'h2, 64'h0, 1'b0, 2'd0, 1'b0);
        total++; if (r_res !== 72'h4) begin bad++; $display("FAIL abort_fresh got=%0h want=4", r_res); end
        total++; if (r_lat !== 1) begin bad++; $display("FAIL abort_fresh_lat got=%0d want=1", r_lat); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode2_full;
        test_mode1;
        test_chain;
        test_ignore_start;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
